// File: rtl/traffic_lights_monitor.sv
// -----------------------------------------------------------------------------
// traffic_lights_monitor
//
// Passive observer of the traffic light controller lamp outputs. Rebuilds the
// timed lamp segments, reports each finished segment with its length, counts
// green blink half-periods, classifies the operating mode and flags lamp
// combinations the controller can never legally drive.
//
// Parameters
//   BLINK_HALF_PERIOD  expected blink half-period (cycles), used for UNC detection
//   DARK_TIMEOUT       cycles of continuous all-dark before mode becomes OFF
//
// Ports
//   clk_i           clock
//   srst_n_i        synchronous reset, active low
//   red_i/yellow_i/green_i  observed lamps
//   clr_err_i       clears illegal_o (a simultaneous new illegal pattern wins)
//   seg_valid_o     one-cycle pulse, segment report valid
//   seg_lights_o    {red,yellow,green} of the finished segment
//   seg_len_o       finished segment length in cycles, saturating at 16'hFFFF
//   blinks_valid_o  one-cycle pulse, green_blinks_o updated
//   green_blinks_o  green half-periods seen in the last blink phase
//   mode_o          0 UNKNOWN, 1 NORMAL, 2 UNC, 3 OFF
//   illegal_o       sticky illegal-pattern flag
// -----------------------------------------------------------------------------
module traffic_lights_monitor #(
  parameter int BLINK_HALF_PERIOD = 500,
  parameter int DARK_TIMEOUT      = 2000
) (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic        red_i,
  input  logic        yellow_i,
  input  logic        green_i,
  input  logic        clr_err_i,
  output logic        seg_valid_o,
  output logic [2:0]  seg_lights_o,
  output logic [15:0] seg_len_o,
  output logic        blinks_valid_o,
  output logic [15:0] green_blinks_o,
  output logic [1:0]  mode_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    MODE_UNKNOWN = 2'd0,
    MODE_NORMAL  = 2'd1,
    MODE_UNC     = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  localparam logic [2:0]  PAT_DARK    = 3'b000;
  localparam logic [2:0]  PAT_GREEN   = 3'b001;
  localparam logic [2:0]  PAT_YELLOW  = 3'b010;
  localparam logic [2:0]  PAT_RED_YEL = 3'b110;
  localparam logic [15:0] BLINK_LEN   = 16'(BLINK_HALF_PERIOD);
  localparam logic [15:0] DARK_LEN    = 16'(DARK_TIMEOUT);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic is_illegal(input logic [2:0] p);
    return (p == 3'b011) || (p == 3'b101) || (p == 3'b111);
  endfunction

  logic [2:0]  pat_p0;
  logic [2:0]  cur_p1;
  logic [15:0] len_p1;
  logic        started_p1;
  logic        seg_change;
  logic        rpt;
  logic        illegal_now;
  logic [2:0]  prev_lights_q;
  mode_e       mode_q;
  mode_e       mode_d;
  logic        disarm;
  logic        armed_q;
  logic        counting_q;
  logic [15:0] blink_cnt_q;

  assign seg_change  = (pat_p0 != cur_p1);
  // The segment that was in progress at reset has no known start, so the
  // first boundary after reset only enables reporting.
  assign rpt         = seg_change && started_p1;
  assign illegal_now = is_illegal(pat_p0);
  assign mode_o      = mode_q;

  // ---- stage p0: lamp sampling ----
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) pat_p0 <= 3'b000;
    else           pat_p0 <= {red_i, yellow_i, green_i};
  end

  // ---- stage p1: segment tracking and reports ----
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      cur_p1       <= 3'b000;
      len_p1       <= 16'd0;
      started_p1   <= 1'b0;
      seg_valid_o  <= 1'b0;
      seg_lights_o <= 3'b000;
      seg_len_o    <= 16'd0;
    end else begin
      seg_valid_o <= 1'b0;
      if (!seg_change) begin
        len_p1 <= sat_inc(len_p1);
      end else begin
        cur_p1     <= pat_p0;
        len_p1     <= 16'd1;
        started_p1 <= 1'b1;
        if (started_p1) begin
          seg_valid_o  <= 1'b1;
          seg_lights_o <= cur_p1;
          seg_len_o    <= len_p1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i)        illegal_o <= 1'b0;
    else if (illegal_now) illegal_o <= 1'b1;
    else if (clr_err_i)   illegal_o <= 1'b0;
  end

  // ---- stage p2: mode classification from registered reports ----
  always_comb begin
    mode_d = mode_q;
    if (illegal_now) begin
      mode_d = MODE_UNKNOWN;
    end else if ((cur_p1 == PAT_DARK) && (len_p1 == DARK_LEN)) begin
      // Fires while the dark segment is still running.
      mode_d = MODE_OFF;
    end else if (seg_valid_o && (seg_lights_o == PAT_DARK) &&
                 (seg_len_o == BLINK_LEN) && (prev_lights_q == PAT_YELLOW)) begin
      mode_d = MODE_UNC;
    end else if (seg_valid_o && (seg_lights_o == PAT_RED_YEL)) begin
      mode_d = MODE_NORMAL;
    end
  end

  assign disarm = (mode_d != mode_q) && (mode_d != MODE_NORMAL);

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      mode_q        <= MODE_UNKNOWN;
      prev_lights_q <= 3'b000;
    end else begin
      mode_q <= mode_d;
      if (seg_valid_o) prev_lights_q <= seg_lights_o;
    end
  end

  // Blink counting follows the tracker reports directly so that the final
  // count can be published in the same cycle as the report of the last
  // green half-period.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      armed_q        <= 1'b0;
      counting_q     <= 1'b0;
      blink_cnt_q    <= 16'd0;
      blinks_valid_o <= 1'b0;
      green_blinks_o <= 16'd0;
    end else begin
      blinks_valid_o <= 1'b0;
      if (rpt) begin
        if (cur_p1 == PAT_RED_YEL) begin
          armed_q     <= 1'b1;
          counting_q  <= 1'b0;
          blink_cnt_q <= 16'd0;
        end else if (counting_q && (pat_p0 == PAT_YELLOW)) begin
          // The half-period ending right now is part of the phase.
          green_blinks_o <= sat_inc(blink_cnt_q);
          blinks_valid_o <= 1'b1;
          armed_q        <= 1'b0;
          counting_q     <= 1'b0;
        end else if (counting_q && ((cur_p1 == PAT_DARK) || (cur_p1 == PAT_GREEN))) begin
          blink_cnt_q <= sat_inc(blink_cnt_q);
        end else if (armed_q && (cur_p1 == PAT_GREEN)) begin
          // Steady green ends; blinking starts with the next segment.
          counting_q <= 1'b1;
        end
      end
      if (disarm) begin
        armed_q    <= 1'b0;
        counting_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_lights_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_lights_monitor
//
// Directed bench for traffic_lights_monitor with BLINK_HALF_PERIOD = 5 and
// DARK_TIMEOUT = 20. Inputs change just after the falling edge; outputs are
// sampled 1 time unit after the falling edge. A monitor collects every report
// pulse into a queue that the directed sequence compares against hand values.
// -----------------------------------------------------------------------------
module tb_traffic_lights_monitor;

  logic        clk;
  logic        srst_n;
  logic        red;
  logic        yellow;
  logic        green;
  logic        clr_err;
  logic        seg_valid_o;
  logic [2:0]  seg_lights_o;
  logic [15:0] seg_len_o;
  logic        blinks_valid_o;
  logic [15:0] green_blinks_o;
  logic [1:0]  mode_o;
  logic        illegal_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0]  l;
    logic [15:0] n;
    logic        bv;
    logic [15:0] gb;
  } rec_t;

  rec_t q[$];
  rec_t mon_r;

  traffic_lights_monitor #(
    .BLINK_HALF_PERIOD(5),
    .DARK_TIMEOUT(20)
  ) dut (
    .clk_i(clk),
    .srst_n_i(srst_n),
    .red_i(red),
    .yellow_i(yellow),
    .green_i(green),
    .clr_err_i(clr_err),
    .seg_valid_o(seg_valid_o),
    .seg_lights_o(seg_lights_o),
    .seg_len_o(seg_len_o),
    .blinks_valid_o(blinks_valid_o),
    .green_blinks_o(green_blinks_o),
    .mode_o(mode_o),
    .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (srst_n && (seg_valid_o || blinks_valid_o)) begin
      mon_r.l  = seg_lights_o;
      mon_r.n  = seg_len_o;
      mon_r.bv = blinks_valid_o;
      mon_r.gb = green_blinks_o;
      q.push_back(mon_r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Missing records show up as all-ones; gb is only meaningful with bv.
  task automatic chk_rec(input string tag, input int idx, input logic [2:0] l,
                         input logic [15:0] n, input logic bv, input logic [15:0] gb);
    logic [63:0] obs;
    logic [63:0] exp;
    exp = 64'({1'b0, l, n, bv, gb});
    if (idx < q.size())
      obs = 64'({1'b0, q[idx].l, q[idx].n, q[idx].bv, (q[idx].bv ? q[idx].gb : 16'h0)});
    else
      obs = '1;
    chk(tag, obs, exp);
  endtask

  task automatic hold(input logic [2:0] p, input int n);
    {red, yellow, green} = p;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    srst_n  = 1'b0;
    clr_err = 1'b0;
    {red, yellow, green} = 3'b000;

    // reset state
    hold(3'b000, 3);
    chk("rst_seg_valid",    64'(seg_valid_o),    64'(0));
    chk("rst_seg_lights",   64'(seg_lights_o),   64'(0));
    chk("rst_seg_len",      64'(seg_len_o),      64'(0));
    chk("rst_blinks_valid", 64'(blinks_valid_o), 64'(0));
    chk("rst_green_blinks", 64'(green_blinks_o), 64'(0));
    chk("rst_mode",         64'(mode_o),         64'(0));
    chk("rst_illegal",      64'(illegal_o),      64'(0));

    // first segment after reset (dark) is never reported; 100 then 110
    srst_n = 1'b1;
    hold(3'b000, 2);
    hold(3'b100, 10);
    hold(3'b110, 3);
    hold(3'b001, 2);
    chk("ry_report_valid",  64'(seg_valid_o),  64'(1));
    chk("ry_report_lights", 64'(seg_lights_o), 64'(3'b110));
    chk("ry_report_len",    64'(seg_len_o),    64'(3));
    chk("ry_mode_before",   64'(mode_o),       64'(0));
    hold(3'b001, 1);
    chk("ry_mode_normal",   64'(mode_o),       64'(1));
    chk("ry_pulse_single",  64'(seg_valid_o),  64'(0));
    hold(3'b001, 5);

    // blink phase: 000/001/000/001 then yellow
    hold(3'b000, 5);
    hold(3'b001, 5);
    hold(3'b000, 5);
    hold(3'b001, 5);
    hold(3'b010, 3);
    hold(3'b100, 3);
    chk("norm_count", 64'(q.size()), 64'(8));
    chk_rec("norm_r0_red",     0, 3'b100, 16'd10, 1'b0, 16'd0);
    chk_rec("norm_r1_redyel",  1, 3'b110, 16'd3,  1'b0, 16'd0);
    chk_rec("norm_r2_green",   2, 3'b001, 16'd8,  1'b0, 16'd0);
    chk_rec("norm_r3_dark",    3, 3'b000, 16'd5,  1'b0, 16'd0);
    chk_rec("norm_r4_green",   4, 3'b001, 16'd5,  1'b0, 16'd0);
    chk_rec("norm_r5_dark",    5, 3'b000, 16'd5,  1'b0, 16'd0);
    chk_rec("norm_r6_blinks",  6, 3'b001, 16'd5,  1'b1, 16'd4);
    chk_rec("norm_r7_yellow",  7, 3'b010, 16'd3,  1'b0, 16'd0);
    chk("norm_mode_kept", 64'(mode_o), 64'(1));
    q.delete();

    // uncontrolled blink: 010/000 every 5 cycles
    hold(3'b100, 1);
    hold(3'b010, 5);
    hold(3'b000, 5);
    hold(3'b010, 2);
    chk("unc_dark_valid", 64'(seg_valid_o),  64'(1));
    chk("unc_dark_lights",64'(seg_lights_o), 64'(3'b000));
    chk("unc_dark_len",   64'(seg_len_o),    64'(5));
    chk("unc_mode_before",64'(mode_o),       64'(1));
    hold(3'b010, 1);
    chk("unc_mode",       64'(mode_o),       64'(2));
    hold(3'b010, 2);
    chk("unc_count", 64'(q.size()), 64'(3));
    chk_rec("unc_r0_red", 0, 3'b100, 16'd4, 1'b0, 16'd0);
    q.delete();

    // dark for 25 cycles: OFF the cycle after len reaches 20
    hold(3'b000, 21);
    chk("off_mode_at_20", 64'(mode_o), 64'(2));
    hold(3'b000, 1);
    chk("off_mode",       64'(mode_o), 64'(3));
    hold(3'b000, 3);
    chk("off_no_report", 64'(q.size()), 64'(1));
    chk_rec("off_r0_yellow", 0, 3'b010, 16'd5, 1'b0, 16'd0);
    q.delete();

    // illegal 111 for one cycle inside green
    hold(3'b001, 4);
    hold(3'b111, 1);
    chk("ill_not_yet",      64'(illegal_o),    64'(0));
    hold(3'b001, 1);
    chk("ill_set",          64'(illegal_o),    64'(1));
    chk("ill_mode_unknown", 64'(mode_o),       64'(0));
    chk("ill_green_valid",  64'(seg_valid_o),  64'(1));
    chk("ill_green_lights", 64'(seg_lights_o), 64'(3'b001));
    chk("ill_green_len",    64'(seg_len_o),    64'(4));
    hold(3'b001, 1);
    chk("ill_seg_valid",    64'(seg_valid_o),  64'(1));
    chk("ill_seg_lights",   64'(seg_lights_o), 64'(3'b111));
    chk("ill_seg_len",      64'(seg_len_o),    64'(1));
    hold(3'b001, 2);
    chk_rec("ill_r0_dark", 0, 3'b000, 16'd25, 1'b0, 16'd0);
    clr_err = 1'b1;
    hold(3'b001, 1);
    clr_err = 1'b0;
    chk("ill_cleared", 64'(illegal_o), 64'(0));
    // set and clear in the same cycle: set wins
    hold(3'b101, 1);
    clr_err = 1'b1;
    hold(3'b001, 1);
    chk("ill_set_wins", 64'(illegal_o), 64'(1));
    hold(3'b001, 1);
    clr_err = 1'b0;
    chk("ill_cleared2", 64'(illegal_o), 64'(0));
    chk("ill_mode_kept", 64'(mode_o), 64'(0));
    q.delete();

    // length saturation
    hold(3'b100, 70000);
    hold(3'b110, 2);
    chk("sat_valid",  64'(seg_valid_o),  64'(1));
    chk("sat_lights", 64'(seg_lights_o), 64'(3'b100));
    chk("sat_len",    64'(seg_len_o),    64'(16'hFFFF));

    // reset asserted mid-segment
    hold(3'b011, 1);
    hold(3'b001, 5);
    chk("mid_illegal_before", 64'(illegal_o), 64'(1));
    srst_n = 1'b0;
    hold(3'b001, 1);
    chk("mid_rst_lights",  64'(seg_lights_o),   64'(0));
    chk("mid_rst_len",     64'(seg_len_o),      64'(0));
    chk("mid_rst_blinks",  64'(green_blinks_o), 64'(0));
    chk("mid_rst_mode",    64'(mode_o),         64'(0));
    chk("mid_rst_illegal", 64'(illegal_o),      64'(0));
    chk("mid_rst_valid",   64'(seg_valid_o),    64'(0));
    srst_n = 1'b1;
    q.delete();
    hold(3'b000, 3);
    hold(3'b100, 3);
    chk("mid_first_unreported", 64'(q.size()), 64'(0));
    hold(3'b110, 2);
    chk("mid_count", 64'(q.size()), 64'(1));
    chk_rec("mid_r0_red", 0, 3'b100, 16'd3, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
